mem_data_interface: RTL and testbench
=====================================

Name: mem_data_interface

Overview:
- Owns the MAR and MDR registers and the request/ready handshake to word-addressed external memory.
- Produces MDR_Bus_lines, the MDR source of the datapath bus multiplexer; loads MAR/MDR from BusMuxOut.
- Sits between the single-bus datapath and the memory block; the control unit drives it with one-cycle strobes.

Parameters:
- DATA_W, 32, bus and memory word width
- ADDR_W, 9, memory address width; MAR holds BusMuxOut[ADDR_W-1:0]
- TIMEOUT, 16, maximum wait cycles for mem_ready before abort (>=2)

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous active-high reset
- BusMuxOut  in  DATA_W  datapath bus value
- MARin  in  1  load MAR from bus
- MDRin  in  1  load MDR from bus
- Read  in  1  one-cycle strobe: start memory read
- Write  in  1  one-cycle strobe: start memory write
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion for the current request
- mem_addr  out  ADDR_W  address to memory (= MAR)
- mem_wdata  out  DATA_W  write data (= MDR)
- mem_rd  out  1  read request level
- mem_wr  out  1  write request level
- MDR_Bus_lines  out  DATA_W  MDR contents to the bus mux
- busy  out  1  request in flight
- done  out  1  one-cycle pulse: access completed
- err  out  1  one-cycle pulse: timeout or illegal strobe

Behaviour:
- Reset (async, any state): MAR=0, MDR=0, state=IDLE, wait counter=0; mem_rd, mem_wr, busy, done, err all 0.
- States: IDLE, RD_WAIT, WR_WAIT. All outputs registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE: MARin loads MAR; MDRin loads MDR; both may load in the same cycle.
- IDLE, Read=1, Write=0 -> RD_WAIT. IDLE, Write=1, Read=0 -> WR_WAIT. Read and Write together: no transition, err pulses next cycle.
- A MARin/MDRin in the same cycle as the strobe takes effect; the request uses the new values.
- RD_WAIT: mem_rd=1, busy=1. When mem_ready is sampled high, MDR<=mem_rdata, state->IDLE, and done=1 for the following cycle.
- WR_WAIT: mem_wr=1, busy=1, mem_wdata=MDR held stable. When mem_ready is sampled high, state->IDLE and done=1 for the following cycle; MDR is unchanged.
- Minimum latency: strobe at cycle 0, request in cycle 1, ready in cycle 1 gives done in cycle 2.
- Timeout counter clears on entry to a WAIT state and increments each WAIT cycle without ready.
  - After TIMEOUT request cycles without ready: state->IDLE, err=1 the next cycle, MDR unchanged, no done.
  - Ready on the final allowed cycle counts as success.
- While busy: MARin, MDRin, Read and Write are ignored; MAR and MDR are stable except for the read capture.
- mem_ready in IDLE is ignored.
- done and err are never high together.
- MDR_Bus_lines = MDR at all times.
- mem_addr = MAR at all times; upper bus bits are discarded on MAR load.
- clear mid-request: immediate return to IDLE; request lines drop asynchronously; no done or err pulse.

Decomposition:
- Shared package (cpu_pkg): state encoding constants, default DATA_W/ADDR_W, memory depth constant.
- Single module. The wait/timeout counter stays inline; a separate sub-module is not warranted.

Test Plan:
- Reset, then MARin with bus=0x0000_0155 -> mem_addr=0x155. MDRin with bus=0xDEAD_BEEF -> MDR_Bus_lines=0xDEAD_BEEF. All handshake outputs 0.
- Read with MAR=0x010, memory returns 0x1234_5678 after 3 wait cycles -> mem_rd high for exactly 4 cycles; MDR_Bus_lines=0x1234_5678 and done=1 the cycle after ready; busy falls with done.
- Write with MAR=0x1FF, MDR=0xA5A5_A5A5, ready on the first cycle -> mem_wr high 1 cycle with mem_wdata=0xA5A5_A5A5; done the next cycle; MDR unchanged.
- Read with ready never asserted, TIMEOUT=16 -> mem_rd high 16 cycles, then err pulse, MDR keeps its prior value, no done. Ready on the 16th cycle instead -> done and no err.
- Read and Write strobed together -> no request, err one cycle. MDRin=0xFFFF_FFFF during RD_WAIT -> ignored; MDR ends holding mem_rdata.
- clear asserted mid-WR_WAIT -> mem_wr, busy and MAR drop to 0 immediately. No done or err follows; the next Read works normally.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : cpu_pkg                                                      |
// | Description : Shared constants and types for the single-bus CPU slice:     |
// |               default bus/address widths, memory depth, default memory     |
// |               wait timeout and the memory-interface state encoding.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cpu_pkg;

  // Default datapath and memory geometry
  localparam int C_DATA_W    = 32;
  localparam int C_ADDR_W    = 9;
  localparam int C_MEM_DEPTH = 1 << C_ADDR_W;

  // Default number of request cycles allowed before a memory access is aborted
  localparam int C_TIMEOUT   = 16;

  // Memory interface sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RD_WAIT = 2'b01,
    ST_WR_WAIT = 2'b10
  } mdi_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/mem_data_interface.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_data_interface                                           |
// | Description : Owns MAR/MDR and the request/ready handshake to word-        |
// |               addressed external memory. MAR/MDR load from the datapath    |
// |               bus; MDR feeds the bus mux. Read/Write strobes start a       |
// |               request that completes on mem_ready or aborts on timeout.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clock          in   1       system clock, rising edge                    |
// |   clear          in   1       asynchronous active-high reset               |
// |   BusMuxOut      in   DATA_W  datapath bus value                           |
// |   MARin/MDRin    in   1       load MAR / MDR from the bus (idle only)      |
// |   Read/Write     in   1       one-cycle strobes starting an access         |
// |   mem_rdata      in   DATA_W  memory read data, valid with mem_ready       |
// |   mem_ready      in   1       memory completion for the current request    |
// |   mem_addr       out  ADDR_W  address to memory (MAR)                      |
// |   mem_wdata      out  DATA_W  write data (MDR)                             |
// |   mem_rd/mem_wr  out  1       request levels                               |
// |   MDR_Bus_lines  out  DATA_W  MDR contents to the bus mux                  |
// |   busy           out  1       request in flight                            |
// |   done           out  1       one-cycle pulse: access completed            |
// |   err            out  1       one-cycle pulse: timeout or illegal strobe   |
// +----------------------------------------------------------------------------+
module mem_data_interface
  import cpu_pkg::*;
#(
  parameter int DATA_W  = C_DATA_W,
  parameter int ADDR_W  = C_ADDR_W,
  parameter int TIMEOUT = C_TIMEOUT
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] MDR_Bus_lines,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Counter holds 0 .. TIMEOUT-1; the last value marks the final allowed cycle.
  localparam int                 C_CNT_W    = $clog2(TIMEOUT);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT - 1);

  mdi_state_t          r_state;
  mdi_state_t          w_state_next;
  logic [ADDR_W-1:0]   r_mar;
  logic [ADDR_W-1:0]   w_mar_next;
  logic [DATA_W-1:0]   r_mdr;
  logic [DATA_W-1:0]   w_mdr_next;
  logic [C_CNT_W-1:0]  r_cnt;
  logic [C_CNT_W-1:0]  w_cnt_next;
  logic                r_done;
  logic                w_done_next;
  logic                r_err;
  logic                w_err_next;

  // State and datapath registers. clear acts asynchronously so the request
  // lines, which decode from state, drop without waiting for a clock edge.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_mar   <= '0;
      r_mdr   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_mar   <= w_mar_next;
      r_mdr   <= w_mdr_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
    end
  end

  // Next-state and register-update logic
  always_comb begin
    w_state_next = r_state;
    w_mar_next   = r_mar;
    w_mdr_next   = r_mdr;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Loads apply even when a strobe arrives in the same cycle, so the
        // request that follows already uses the freshly loaded values.
        if (MARin) w_mar_next = BusMuxOut[ADDR_W-1:0];
        if (MDRin) w_mdr_next = BusMuxOut;
        // Cleared here so every WAIT state is entered with a zero count.
        w_cnt_next = '0;
        if (Read && Write) begin
          w_err_next = 1'b1;
        end else if (Read) begin
          w_state_next = ST_RD_WAIT;
        end else if (Write) begin
          w_state_next = ST_WR_WAIT;
        end
      end

      ST_RD_WAIT: begin
        // Ready wins over timeout, so ready on the last allowed cycle succeeds.
        if (mem_ready) begin
          w_mdr_next   = mem_rdata;
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_next = ST_IDLE;
          w_err_next   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + C_CNT_W'(1);
        end
      end

      ST_WR_WAIT: begin
        if (mem_ready) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_next = ST_IDLE;
          w_err_next   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + C_CNT_W'(1);
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs come from registers or a state decode only.
  assign mem_addr      = r_mar;
  assign mem_wdata     = r_mdr;
  assign MDR_Bus_lines = r_mdr;
  assign mem_rd        = (r_state == ST_RD_WAIT);
  assign mem_wr        = (r_state == ST_WR_WAIT);
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;
  assign err           = r_err;

endmodule : mem_data_interface
`default_nettype wire

// File: tb/tb_mem_data_interface.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_data_interface                                        |
// | Description : Self-checking bench for mem_data_interface. Stimulus tasks   |
// |               update a behavioural MAR/MDR model and push the expected     |
// |               completion into a scoreboard queue; a monitor pops it when   |
// |               done or err pulses.                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_data_interface;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 16;

  logic              clock = 1'b0;
  logic              clear;
  logic [DATA_W-1:0] BusMuxOut;
  logic              MARin;
  logic              MDRin;
  logic              Read;
  logic              Write;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] MDR_Bus_lines;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clock = ~clock;

  mem_data_interface #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock        (clock),
    .clear        (clear),
    .BusMuxOut    (BusMuxOut),
    .MARin        (MARin),
    .MDRin        (MDRin),
    .Read         (Read),
    .Write        (Write),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .MDR_Bus_lines(MDR_Bus_lines),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  // Expected completion of one access
  typedef struct packed {
    logic              is_err;
    logic [DATA_W-1:0] mdr;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural model: just the two registers the programmer sees
  logic [ADDR_W-1:0] m_mar;
  logic [DATA_W-1:0] m_mdr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done/err pulse must match the oldest outstanding access.
  always @(negedge clock) begin
    if (!clear && (done || err)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: done=%0b err=%0b with no access pending at %0t",
                 done, err, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_err_flag", {63'd0, err}, {63'd0, mon_e.is_err});
        chk("sb_done_flag", {63'd0, done}, {63'd0, ~mon_e.is_err});
        chk("sb_mdr", {32'd0, MDR_Bus_lines}, {32'd0, mon_e.mdr});
        chk("sb_addr", {55'd0, mem_addr}, {55'd0, mon_e.addr});
        chk("sb_busy_low", {63'd0, busy}, 64'd0);
      end
    end
  end

  task automatic load(input bit ld_mar, input bit ld_mdr, input logic [DATA_W-1:0] v);
    MARin     = ld_mar;
    MDRin     = ld_mdr;
    BusMuxOut = v;
    @(negedge clock);
    MARin = 1'b0;
    MDRin = 1'b0;
    if (ld_mar) m_mar = v[ADDR_W-1:0];
    if (ld_mdr) m_mdr = v;
    chk("load_mar", {55'd0, mem_addr}, {55'd0, m_mar});
    chk("load_mdr", {32'd0, MDR_Bus_lines}, {32'd0, m_mdr});
  endtask

  // One access. latency = wait cycles before ready; latency >= TIMEOUT means
  // memory never answers. noise toggles loads/strobes that must be ignored.
  task automatic do_access(input bit is_read, input int latency, input bit ld_mar,
                           input bit ld_mdr, input logic [DATA_W-1:0] bus,
                           input logic [DATA_W-1:0] rdata, input bit noise);
    exp_t e;
    int   req_cycles;
    int   exp_cycles;
    bit   finished;
    Read      = is_read;
    Write     = !is_read;
    MARin     = ld_mar;
    MDRin     = ld_mdr;
    BusMuxOut = bus;
    if (ld_mar) m_mar = bus[ADDR_W-1:0];
    if (ld_mdr) m_mdr = bus;
    if (latency < TIMEOUT) begin
      e.is_err   = 1'b0;
      exp_cycles = latency + 1;
    end else begin
      e.is_err   = 1'b1;
      exp_cycles = TIMEOUT;
    end
    // Write data seen by memory is the MDR before any read capture.
    e.mdr  = (is_read && latency < TIMEOUT) ? rdata : m_mdr;
    e.addr = m_mar;
    sb.push_back(e);
    @(negedge clock);
    Read  = 1'b0;
    Write = 1'b0;
    MARin = 1'b0;
    MDRin = 1'b0;
    req_cycles = 0;
    finished   = 1'b0;
    for (int k = 0; k < TIMEOUT + 4; k++) begin
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      if (is_read ? mem_rd : mem_wr) req_cycles++;
      chk("req_addr", {55'd0, mem_addr}, {55'd0, m_mar});
      chk("req_other_line", {63'd0, (is_read ? mem_wr : mem_rd)}, 64'd0);
      if (!is_read) chk("req_wdata", {32'd0, mem_wdata}, {32'd0, m_mdr});
      mem_ready = (k == latency);
      mem_rdata = (k == latency) ? rdata : $urandom();
      if (noise) begin
        BusMuxOut = 32'hFFFF_FFFF;
        MDRin     = 1'($urandom_range(0, 1));
        MARin     = 1'($urandom_range(0, 1));
        Read      = 1'($urandom_range(0, 1));
        Write     = 1'($urandom_range(0, 1));
      end
      @(negedge clock);
      mem_ready = 1'b0;
      MDRin     = 1'b0;
      MARin     = 1'b0;
      Read      = 1'b0;
      Write     = 1'b0;
    end
    if (!finished) chk("access_bound_busy", {63'd0, busy}, 64'd0);
    chk("req_cycles", 64'(req_cycles), 64'(exp_cycles));
    m_mdr = e.mdr;
  endtask

  task automatic both_strobes();
    exp_t e;
    e.is_err = 1'b1;
    e.mdr    = m_mdr;
    e.addr   = m_mar;
    sb.push_back(e);
    Read  = 1'b1;
    Write = 1'b1;
    @(negedge clock);
    Read  = 1'b0;
    Write = 1'b0;
    chk("both_busy", {63'd0, busy}, 64'd0);
    chk("both_rd", {63'd0, mem_rd}, 64'd0);
    chk("both_wr", {63'd0, mem_wr}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear     = 1'b1;
    BusMuxOut = '0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    Read      = 1'b0;
    Write     = 1'b0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    m_mar     = '0;
    m_mdr     = '0;
    repeat (2) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);

    // Reset state
    chk("rst_mem_addr", {55'd0, mem_addr}, 64'd0);
    chk("rst_mdr", {32'd0, MDR_Bus_lines}, 64'd0);
    chk("rst_mem_rd", {63'd0, mem_rd}, 64'd0);
    chk("rst_mem_wr", {63'd0, mem_wr}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);

    // Register loads, upper bus bits dropped on MAR
    load(1'b1, 1'b0, 32'h0000_0155);
    load(1'b0, 1'b1, 32'hDEAD_BEEF);
    load(1'b1, 1'b0, 32'hFFFF_FE10);

    // Read, three wait cycles -> four request cycles
    load(1'b1, 1'b0, 32'h0000_0010);
    do_access(1'b1, 3, 1'b0, 1'b0, '0, 32'h1234_5678, 1'b0);

    // Write, ready on first cycle
    load(1'b1, 1'b0, 32'h0000_01FF);
    load(1'b0, 1'b1, 32'hA5A5_A5A5);
    do_access(1'b0, 0, 1'b0, 1'b0, '0, 32'h0BAD_F00D, 1'b0);
    chk("wr_mdr_kept", {32'd0, MDR_Bus_lines}, 64'h0000_0000_A5A5_A5A5);

    // Timeout, then ready on the final allowed cycle
    do_access(1'b1, TIMEOUT, 1'b0, 1'b0, '0, 32'h5555_AAAA, 1'b0);
    do_access(1'b1, TIMEOUT - 1, 1'b0, 1'b0, '0, 32'hCAFE_0001, 1'b0);
    do_access(1'b0, TIMEOUT, 1'b0, 1'b0, '0, 32'h0, 1'b0);

    // Illegal double strobe, and loads ignored while busy
    both_strobes();
    do_access(1'b1, 2, 1'b0, 1'b0, '0, 32'h7654_3210, 1'b1);

    // Loads in the strobe cycle feed the request
    do_access(1'b0, 1, 1'b1, 1'b1, 32'h1357_90AB, 32'h0, 1'b0);

    // mem_ready while idle is ignored
    mem_ready = 1'b1;
    mem_rdata = 32'hFEED_FACE;
    @(negedge clock);
    mem_ready = 1'b0;
    @(negedge clock);
    chk("idle_ready_mdr", {32'd0, MDR_Bus_lines}, {32'd0, m_mdr});
    chk("idle_ready_busy", {63'd0, busy}, 64'd0);

    // clear mid-write
    load(1'b1, 1'b1, 32'h2468_A0C2);
    Write = 1'b1;
    @(negedge clock);
    Write = 1'b0;
    @(negedge clock);
    chk("pre_clear_mem_wr", {63'd0, mem_wr}, 64'd1);
    #2;
    clear = 1'b1;
    #1;
    m_mar = '0;
    m_mdr = '0;
    chk("clear_mem_wr", {63'd0, mem_wr}, 64'd0);
    chk("clear_busy", {63'd0, busy}, 64'd0);
    chk("clear_mar", {55'd0, mem_addr}, 64'd0);
    chk("clear_mdr", {32'd0, MDR_Bus_lines}, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    repeat (3) @(negedge clock);
    do_access(1'b1, 1, 1'b1, 1'b0, 32'h0000_0033, 32'h0F0F_0F0F, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        both_strobes();
      end else if (sel == 1) begin
        load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom());
      end else begin
        do_access(1'($urandom_range(0, 1)), int'($urandom_range(0, TIMEOUT + 2)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom(), $urandom(), 1'($urandom_range(0, 1)));
      end
    end

    repeat (3) @(negedge clock);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("final_mar", {55'd0, mem_addr}, {55'd0, m_mar});
    chk("final_mdr", {32'd0, MDR_Bus_lines}, {32'd0, m_mdr});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_data_interface
`default_nettype wire
